// File: rtl/clk_rate_sched_if.sv
// rtl/clk_rate_sched_if.sv - config request/response port of the clock-rate scheduler
interface clk_rate_sched_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_en;
    logic [3:0] cfg_rate;
    logic       cfg_done;
    logic       cfg_err;

    modport master (
        output cfg_valid,
        output cfg_en,
        output cfg_rate,
        input  cfg_ready,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_en,
        input  cfg_rate,
        output cfg_ready,
        output cfg_done,
        output cfg_err
    );
endinterface

// File: rtl/clk_rate_sched.sv
// rtl/clk_rate_sched.sv - power-of-two divided clock/strobe generator with glitch-free rate switching
module clk_rate_sched #(
    parameter int CNT_W = 15
) (
    input  logic                   clk32M768,
    input  logic                   rst,
    clk_rate_sched_if.slave        cfg,
    output logic                   clk_o,
    output logic                   strobe_o,
    output logic                   busy_o,
    output logic [3:0]             rate_o,
    output logic                   en_o
);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_RUNNING,
        ST_SWITCHING
    } state_t;

    localparam logic [3:0] MAX_RATE = 4'(CNT_W - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cur_en_q;
    logic [3:0]       cur_rate_q;
    logic             tgt_en_q;
    logic [3:0]       tgt_rate_q;
    logic [3:0]       m_q;
    logic [3:0]       m_d;
    logic             done_q;
    logic             err_q;
    logic             clk_q;
    logic             strobe_q;

    logic             accept;
    logic             illegal;
    logic             noop;
    logic             tick_m;
    logic             tick_cur;

    // tick(k): the low k+1 counter bits are all ones, i.e. the last cycle of a 2^(k+1) period
    function automatic logic tick(input logic [CNT_W-1:0] c, input logic [3:0] k);
        logic t;
        t = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            if ((i <= int'(k)) && !c[i]) begin
                t = 1'b0;
            end
        end
        return t;
    endfunction

    // Request classification and the boundary index a pending switch must wait for
    always_comb begin
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        accept   = cfg.cfg_valid && (state_q != ST_SWITCHING);
        illegal  = cfg.cfg_en && (cfg.cfg_rate > MAX_RATE);
        noop     = (!cfg.cfg_en && !cur_en_q) ||
                   (cfg.cfg_en && cur_en_q && (cfg.cfg_rate == cur_rate_q));
        tick_m   = tick(cnt_q, m_q);
        tick_cur = tick(cnt_q, cur_rate_q);
        m_d      = cfg.cfg_rate;
        if (!cur_en_q) begin
            m_d = cfg.cfg_rate;
        end else if (!cfg.cfg_en) begin
            m_d = cur_rate_q;
        end else begin
            // A period boundary of the slower rate is also one of the faster rate
            m_d = (cfg.cfg_rate > cur_rate_q) ? cfg.cfg_rate : cur_rate_q;
        end
    end

    // Divider counter, config FSM and registered clock/strobe outputs
    always_ff @(posedge clk32M768) begin
        if (rst) begin
            state_q    <= ST_DISABLED;
            cnt_q      <= '0;
            cur_en_q   <= 1'b0;
            cur_rate_q <= 4'd0;
            tgt_en_q   <= 1'b0;
            tgt_rate_q <= 4'd0;
            m_q        <= 4'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_q      <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clk_q    <= cur_en_q & cnt_q[cur_rate_q];
            // The enabling boundary gets its own strobe because cur_en is still low there
            strobe_q <= (cur_en_q & tick_cur) |
                        ((state_q == ST_SWITCHING) & tick_m & tgt_en_q);
            case (state_q)
                ST_SWITCHING: begin
                    if (tick_m) begin
                        cur_en_q <= tgt_en_q;
                        if (tgt_en_q) begin
                            cur_rate_q <= tgt_rate_q;
                        end
                        state_q <= tgt_en_q ? ST_RUNNING : ST_DISABLED;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        tgt_en_q   <= cfg.cfg_en;
                        tgt_rate_q <= cfg.cfg_rate;
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else if (noop) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_SWITCHING;
                            m_q     <= m_d;
                        end
                    end
                end
            endcase
        end
    end

    assign cfg.cfg_ready = (state_q != ST_SWITCHING);
    assign cfg.cfg_done  = done_q;
    assign cfg.cfg_err   = err_q;
    assign busy_o        = (state_q == ST_SWITCHING);
    assign clk_o         = clk_q;
    assign strobe_o      = strobe_q;
    assign rate_o        = cur_rate_q;
    assign en_o          = cur_en_q;

endmodule

// File: tb/tb_clk_rate_sched.sv
// tb/tb_clk_rate_sched.sv - scoreboard bench for clk_rate_sched
module tb_clk_rate_sched;

    logic       clk;
    logic       rst;
    logic       clk_o;
    logic       strobe_o;
    logic       busy_o;
    logic [3:0] rate_o;
    logic       en_o;

    clk_rate_sched_if cfg_if();

    clk_rate_sched #(.CNT_W(15)) dut (
        .clk32M768 (clk),
        .rst       (rst),
        .cfg       (cfg_if),
        .clk_o     (clk_o),
        .strobe_o  (strobe_o),
        .busy_o    (busy_o),
        .rate_o    (rate_o),
        .en_o      (en_o)
    );

    typedef struct { bit is_err; int at; } ev_t;
    typedef struct { int end_at; int width; } pul_t;

    ev_t  evq[$];
    pul_t pq[$];
    int   sq[$];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset; equals the divider count while below 32768
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic send(input logic en, input logic [3:0] rate, output int acc);
        int n;
        n = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_en    = en;
        cfg_if.cfg_rate  = rate;
        while (!cfg_if.cfg_ready && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout at cycle %0d: got ready 0 expected 1", cyc);
        end
        acc = cyc;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic push_strobes(input int first, input int period, input int last);
        for (int x = first; x <= last; x += period) sq.push_back(x);
    endtask

    task automatic push_pulses(input int first, input int period, input int last, input int width);
        pul_t p;
        for (int x = first; x <= last; x += period) begin
            p.end_at = x;
            p.width  = width;
            pq.push_back(p);
        end
    endtask

    task automatic push_ev(input bit is_err, input int at);
        ev_t e;
        e.is_err = is_err;
        e.at     = at;
        evq.push_back(e);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"},  int'(cfg_if.cfg_ready), 1);
        chk({tag, "_busy"},   int'(busy_o), 0);
        chk({tag, "_clk"},    int'(clk_o), 0);
        chk({tag, "_strobe"}, int'(strobe_o), 0);
        chk({tag, "_rate"},   int'(rate_o), 0);
        chk({tag, "_en"},     int'(en_o), 0);
        chk({tag, "_done"},   int'(cfg_if.cfg_done), 0);
        chk({tag, "_err"},    int'(cfg_if.cfg_err), 0);
    endtask

    // Monitor: every strobe, done/err pulse and clk_o high pulse is matched against the queues
    bit prev_clk = 1'b0;
    int hi_len   = 0;
    always @(negedge clk) begin
        ev_t  e;
        pul_t p;
        int   s;
        if (rst) begin
            prev_clk = 1'b0;
            hi_len   = 0;
        end else begin
            if (strobe_o) begin
                if (sq.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_strobe at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    s = sq.pop_front();
                    chk("strobe_cycle", cyc, s);
                end
            end
            if (cfg_if.cfg_done || cfg_if.cfg_err) begin
                if (evq.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_cfg_event at cycle %0d: got done=%0d err=%0d expected none",
                             cyc, cfg_if.cfg_done, cfg_if.cfg_err);
                end else begin
                    e = evq.pop_front();
                    chk("ev_err",   int'(cfg_if.cfg_err), int'(e.is_err));
                    chk("ev_done",  int'(cfg_if.cfg_done), int'(!e.is_err));
                    chk("ev_cycle", cyc, e.at);
                end
            end
            if (clk_o) begin
                hi_len++;
            end else if (prev_clk) begin
                if (pq.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_clk_pulse ending %0d: got width %0d expected none", cyc - 1, hi_len);
                end else begin
                    p = pq.pop_front();
                    chk("clk_pulse_end",   cyc - 1, p.end_at);
                    chk("clk_pulse_width", hi_len, p.width);
                end
                hi_len = 0;
            end
            prev_clk = clk_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst              = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_en    = 1'b0;
        cfg_if.cfg_rate  = 4'd0;
        repeat (3) step();
        rst = 1'b0;
        chk_idle("reset");

        // Enable at rate 0: boundary at count 7, done and enabling strobe at 8
        wait_cyc(5);
        push_ev(0, 8);
        push_strobes(8, 2, 32);
        push_pulses(10, 2, 32, 1);
        send(1'b1, 4'd0, acc);
        chk("en0_acc", acc, 5);
        chk("en0_busy", int'(busy_o), 1);
        chk("en0_ready", int'(cfg_if.cfg_ready), 0);
        wait_cyc(9);
        chk("en0_rate", int'(rate_o), 0);
        chk("en0_en", int'(en_o), 1);

        // Rate 0 -> 2 requested on a tick(2) cycle: waits for the next boundary at 31
        wait_cyc(23);
        push_ev(0, 32);
        push_strobes(40, 8, 64);
        push_pulses(40, 8, 64, 4);
        send(1'b1, 4'd2, acc);
        chk("r2_acc", acc, 23);
        wait_cyc(33);
        chk("r2_rate", int'(rate_o), 2);

        // Rate 2 -> 4: boundary at 63
        wait_cyc(40);
        push_ev(0, 64);
        push_strobes(96, 32, 96);
        push_pulses(96, 32, 96, 16);
        send(1'b1, 4'd4, acc);
        chk("r4_busy", int'(busy_o), 1);

        // Rate 4 -> 3 held during the switch: accepted on the done cycle 64, boundary 95
        wait_cyc(50);
        push_ev(0, 96);
        push_strobes(112, 16, 144);
        push_pulses(112, 16, 144, 8);
        send(1'b1, 4'd3, acc);
        chk("r3_held_acc", acc, 64);
        wait_cyc(100);
        chk("r3_rate", int'(rate_o), 3);

        // Disable from rate 3: final strobe at 144
        wait_cyc(130);
        push_ev(0, 144);
        send(1'b0, 4'd0, acc);
        wait_cyc(150);
        chk("dis_en", int'(en_o), 0);
        chk("dis_rate", int'(rate_o), 3);
        chk("dis_clk", int'(clk_o), 0);
        chk("dis_busy", int'(busy_o), 0);

        // Illegal rate rejected; same rate with en=0 while disabled is a no-op
        wait_cyc(160);
        push_ev(1, 161);
        send(1'b1, 4'd15, acc);
        wait_cyc(165);
        chk("ill_rate", int'(rate_o), 3);
        chk("ill_en", int'(en_o), 0);
        wait_cyc(170);
        push_ev(0, 171);
        send(1'b0, 4'd15, acc);

        // Enable rate 1 (boundary 183), no-op repeat, then a long switch to 14 cut by reset
        wait_cyc(180);
        push_ev(0, 184);
        push_strobes(184, 4, 300);
        push_pulses(188, 4, 300, 2);
        send(1'b1, 4'd1, acc);
        wait_cyc(196);
        push_ev(0, 197);
        send(1'b1, 4'd1, acc);
        wait_cyc(200);
        send(1'b1, 4'd14, acc);
        wait_cyc(210);
        chk("r14_busy", int'(busy_o), 1);
        chk("r14_ready", int'(cfg_if.cfg_ready), 0);
        chk("r14_rate_old", int'(rate_o), 1);
        wait_cyc(302);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk_idle("midrst");

        // Fresh rate 14: boundary at 32767, first strobe at 32768, next at 65536
        wait_cyc(3);
        push_ev(0, 32768);
        push_strobes(32768, 32768, 65536);
        push_pulses(65536, 32768, 65536, 16384);
        send(1'b1, 4'd14, acc);
        wait_cyc(100);
        chk("slow_busy", int'(busy_o), 1);
        wait_cyc(32770);
        chk("slow_rate", int'(rate_o), 14);
        chk("slow_en", int'(en_o), 1);
        wait_cyc(65540);

        chk("left_strobes", sq.size(), 0);
        chk("left_events", evq.size(), 0);
        chk("left_pulses", pq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
